rr_burst_arbiter: RTL



---
 rtl/rr_burst_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst hold: grants are held until done, request withdrawal or MAX_BURST.
// Optional RR_TURNAROUND_EN inserts a one-cycle idle gap (GAP state) after every release.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 burst_last
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
`ifdef RR_TURNAROUND_EN
  localparam logic [1:0] S_GAP   = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          burst_last_q, burst_last_d;

  logic          do_arb;
  logic          rel;
  logic [IW-1:0] arb_ptr;
  logic [IW-1:0] ptr_nxt;
  logic [CW-1:0] cnt_inc;
  logic [IW:0]   pick_res;

  // Returns {found, index}: lowest request at or above p, else lowest request overall.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic          found_hi, found_lo;
    logic [IW-1:0] idx_hi, idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i] && (i >= int'(p))) begin
        found_hi = 1'b1;
        idx_hi   = IW'(i);
      end
      if (r[i]) begin
        found_lo = 1'b1;
        idx_lo   = IW'(i);
      end
    end
    return found_hi ? {1'b1, idx_hi} : {found_lo, idx_lo};
  endfunction

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    burst_last_d = 1'b0;
    do_arb       = 1'b0;
    arb_ptr      = ptr_q;
    pick_res     = '0;
    rel          = done || !req[grant_id_q] || (cnt_q == CNT_LAST);
    ptr_nxt      = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
    cnt_inc      = cnt_q + CW'(1);

    case (state_q)
      S_GRANT: begin
        if (rel) begin
          ptr_d = ptr_nxt;
`ifdef RR_TURNAROUND_EN
          state_d = S_GAP;
          grant_d = '0;
          cnt_d   = '0;
`else
          arb_ptr = ptr_nxt;
          do_arb  = 1'b1;
`endif
        end else begin
          cnt_d        = cnt_inc;
          burst_last_d = (cnt_inc == CNT_LAST);
        end
      end
      default: do_arb = 1'b1;
    endcase

    // Handoff path shares the idle arbitration, using the already-advanced pointer.
    if (do_arb) begin
      pick_res = pick(req, arb_ptr);
      cnt_d    = '0;
      if (pick_res[IW]) begin
        state_d      = S_GRANT;
        grant_d      = N'(1) << pick_res[IW-1:0];
        grant_id_d   = pick_res[IW-1:0];
        burst_last_d = (MAX_BURST == 1);
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    end

    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      burst_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      burst_last_q  <= burst_last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign burst_last  = burst_last_q;

endmodule
